branch_predict_btb: RTL and testbench
=====================================

// Module: branch_predict_btb
// PURPOSE
//  Parametrised dynamic branch predictor for the 5-stage RV32 pipeline: direct-mapped BTB with 2-bit counters.
//  IF looks it up with the fetch PC to choose the next PC; EX writes resolved branch/JAL outcomes back.
//  EX gets a mispredict flag and a redirect PC to drive the PC mux and the IF/ID and ID/EX flushes.
//  Replaces the static predict-not-taken path; keeps saturating statistics counters.
// PARAMETERS
//  XLEN      32     address/data width
//  ENTRIES   16     BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
//  CNT_W     16     width of the statistics counters
//  TAG_W     XLEN-IDX_W-2 (derived localparam) tag width
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high reset
//  if_pc           in   XLEN    fetch-stage PC
//  pred_taken      out  1       IF: predict taken (hit and ctr[1]=1, or hit on JAL entry)
//  pred_target     out  XLEN    IF: predicted target; if_pc+4 when pred_taken=0
//  ex_valid        in   1       EX holds a resolved conditional branch or JAL (0 for bubbles/flushed)
//  ex_is_jump      in   1       EX instruction is JAL (always taken); JALR never presented
//  ex_pc           in   XLEN    PC of the EX instruction
//  ex_taken        in   1       actual outcome
//  ex_target       in   XLEN    actual target (PC+imm)
//  ex_pred_taken   in   1       pred_taken carried down the pipe with this instruction
//  ex_pred_target  in   XLEN    pred_target carried down the pipe
//  mispredict      out  1       EX: redirect required (combinational)
//  redirect_pc     out  XLEN    EX: correct next PC; ex_taken ? ex_target : ex_pc+4
//  branch_cnt      out  CNT_W   resolved branches/jumps seen
//  mispred_cnt     out  CNT_W   mispredictions seen
// BEHAVIOUR
//  Reset (async): all valid bits 0, counters 2'b01, jump bits 0, branch_cnt=mispred_cnt=0.
//  Outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0.
//  Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; hit = valid[idx] & (tag[idx]==tag(if_pc)).
//  Lookup: combinational from if_pc, zero latency. Reads pre-edge contents; no write-to-read bypass.
//  Mispredict (only when ex_valid=1):
//   - ex_pred_taken != ex_taken, or
//   - both taken and ex_pred_target != ex_target.
//   - ex_valid=0 forces mispredict=0 and blocks all table and statistics updates.
//  Update on the rising edge when ex_valid=1, at entry i=idx(ex_pc):
//   - hit, conditional: ctr saturating +1 if taken, -1 if not (11 and 00 hold); target<=ex_target if taken.
//   - miss, taken: allocate/replace entry: valid=1, tag, target=ex_target, ctr=2'b10, jump=ex_is_jump.
//   - miss, not taken: no allocation.
//   - JAL (hit or miss): ctr forced 2'b11, jump=1, target refreshed.
//  Statistics, each clock:
//   - branch_cnt += ex_valid; mispred_cnt += mispredict.
//   - Both saturate at all-ones (no wrap).
//  Simultaneous IF lookup and EX update of the same index: IF sees old entry; the update lands at the edge.
//  Aliasing: a tag mismatch counts as a miss; on a taken outcome the newer branch evicts the older one.
//  Wrap-around: if_pc+4 and ex_pc+4 are modulo 2^XLEN.
//  Reset asserted mid-operation: table and statistics clear immediately.
//  Any update in flight is dropped. The pipeline flushes separately.
// STRUCTURE
//  Shared package rv_bp_pkg:
//   - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
//   - CTR_RESET=WNT, CTR_ALLOC=WT;
//   - BTB entry struct {valid, jump, ctr[1:0], tag, target}.
//  One sub-module: sat_ctr2 (combinational 2-bit saturating next-state; inputs ctr, taken, force_st).
//  Storage: flop arrays, not inferred RAM; async reset is required on the valid and ctr fields.
// TESTING
//  1) Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, both counters 0.
//  2) Branch at 0x100, taken to 0x80: ex_valid=1, ex_pred_taken=0 ->
//     mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
//  3) Same branch not taken twice: 1st -> mispredict=1, redirect=0x104, ctr 10->01.
//     2nd -> prediction not-taken, mispredict=0, ctr 00. Further not-taken holds 00.
//  4) JAL at 0x200 to 0x400 -> allocated ctr=11. A not-taken report on that entry is impossible;
//     next lookup predicts 0x400. Aliasing 0x200 vs 0x200+4*ENTRIES: second evicts first.
//  5) Same-index update and lookup in one cycle -> IF sees old entry; new data is visible the next cycle.
//  6) Force 2^CNT_W+3 mispredicts (CNT_W=4 build) -> mispred_cnt holds 0xF.
//     Async reset pulse mid-run clears counters and table within the same cycle.

Source files
------------

// File: rtl/rv_bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings and the BTB entry layout.
// The tag field is sized for the smallest legal table, so narrower tags are zero-extended.
package rv_bp_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_TAG_MAX = BP_XLEN - 3;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  typedef struct packed {
    logic                  valid;
    logic                  jump;
    ctr_t                  ctr;
    logic [BP_TAG_MAX-1:0] tag;
    logic [BP_XLEN-1:0]    target;
  } btb_entry_t;

endpackage

// File: rtl/branch_predict_btb_sat_ctr2.sv
// Combinational next state of a 2-bit saturating counter; force_st pins it to strongly-taken.
module sat_ctr2
  import rv_bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  input  logic force_st,
  output ctr_t nxt
);

  always_comb begin
    nxt = ctr;
    if (force_st)
      nxt = ST;
    else if (taken)
      nxt = (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
    else
      nxt = (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
  end

endmodule

// File: rtl/branch_predict_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, EX resolution and writeback,
// plus saturating branch/mispredict statistics.
module branch_predict_btb
  import rv_bp_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_jump,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  btb_entry_t       if_ent, ex_ent;
  logic             if_hit, ex_hit;
  ctr_t             ex_ctr_nxt;

  function automatic logic [BP_TAG_MAX-1:0] tag_of(input logic [XLEN-1:0] pc);
    return BP_TAG_MAX'(pc[XLEN-1:XLEN-TAG_W]);
  endfunction

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_ent = btb[if_idx];
  assign ex_ent = btb[ex_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == tag_of(if_pc));
  assign ex_hit = ex_ent.valid && (ex_ent.tag == tag_of(ex_pc));

  // A JAL entry predicts taken regardless of its counter.
  assign pred_taken  = if_hit && (if_ent.ctr[1] || if_ent.jump);
  assign pred_target = pred_taken ? if_ent.target : if_pc + XLEN'(4);

  assign mispredict  = ex_valid &&
                       ((ex_pred_taken != ex_taken) ||
                        (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ex_ent.ctr),
    .taken    (ex_taken),
    .force_st (ex_is_jump),
    .nxt      (ex_ctr_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, jump: 1'b0, ctr: CTR_RESET, tag: '0, target: '0};
      end
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ex_valid) begin
        if (ex_is_jump) begin
          btb[ex_idx] <= '{valid: 1'b1, jump: 1'b1, ctr: ex_ctr_nxt,
                           tag: tag_of(ex_pc), target: ex_target};
        end else if (ex_hit) begin
          btb[ex_idx].ctr <= ex_ctr_nxt;
          if (ex_taken) btb[ex_idx].target <= ex_target;
        end else if (ex_taken) begin
          // Miss on a taken branch: the newer branch evicts whatever aliased here.
          btb[ex_idx] <= '{valid: 1'b1, jump: 1'b0, ctr: CTR_ALLOC,
                           tag: tag_of(ex_pc), target: ex_target};
        end
      end
      if (ex_valid && !(&branch_cnt))   branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispredict && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_btb.sv
// Scoreboard bench for branch_predict_btb: directed scenarios then random traffic against a PC-keyed model.
module tb_branch_predict_btb;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
  logic [XLEN-1:0]  ex_pc, ex_target, ex_pred_target;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_predict_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    bit          pt;
    logic [31:0] ptg;
    bit          mp;
    logic [31:0] rpc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int compared   = 0;
  int mismatched = 0;

  // Model: each slot remembers the full PC of the branch owning it and a strength 0..3.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_str   [ENTRIES];
  bit          m_jmp   [ENTRIES];
  int          m_bc, m_mc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit owns(input int i, input logic [31:0] pc);
    return m_valid[i] && ((m_pc[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
  endfunction

  task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] g);
    int i;
    i = slot(pc);
    t = owns(i, pc) && (m_str[i] >= 2 || m_jmp[i]);
    g = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_str[i] = 1; m_jmp[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input logic [31:0] ipc, input bit v, input bit j,
                      input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt);
    exp_t e;
    int   i;
    @(posedge clk); #1;
    reset = rst; if_pc = ipc; ex_valid = v; ex_is_jump = j; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    if (rst) model_clear();
    model_pred(ipc, e.pt, e.ptg);
    e.mp  = v && ((ptk != tk) || (tk && ptk && ptgt != tgt));
    e.rpc = tk ? tgt : epc + 32'd4;
    e.bc  = m_bc;
    e.mc  = m_mc;
    sbq.push_back(e);
    if (v && !rst) begin
      i = slot(epc);
      if (j) begin
        m_valid[i] = 1; m_pc[i] = epc; m_tgt[i] = tgt; m_str[i] = 3; m_jmp[i] = 1;
      end else if (owns(i, epc)) begin
        m_str[i] = tk ? ((m_str[i] == 3) ? 3 : m_str[i] + 1) : ((m_str[i] == 0) ? 0 : m_str[i] - 1);
        if (tk) m_tgt[i] = tgt;
      end else if (tk) begin
        m_valid[i] = 1; m_pc[i] = epc; m_tgt[i] = tgt; m_str[i] = 2; m_jmp[i] = 0;
      end
      if (m_bc < CMAX) m_bc++;
      if (e.mp && m_mc < CMAX) m_mc++;
    end
  endtask

  // EX report whose carried-down prediction is what the predictor currently says for that PC.
  task automatic ex_step(input logic [31:0] ipc, input bit j, input logic [31:0] epc,
                         input bit tk, input logic [31:0] tgt);
    bit          pt;
    logic [31:0] pg;
    model_pred(epc, pt, pg);
    step(0, ipc, 1, j, epc, tk, tgt, pt, pg);
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(0, ipc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      check("pred_taken",  32'(pred_taken),  32'(me.pt));
      check("pred_target", pred_target,      me.ptg);
      check("mispredict",  32'(mispredict),  32'(me.mp));
      check("redirect_pc", redirect_pc,      me.rpc);
      check("branch_cnt",  32'(branch_cnt),  me.bc);
      check("mispred_cnt", 32'(mispred_cnt), me.mc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] epc, ipc, tgt, pg;
    bit          v, j, tk, pt;
    reset = 1'b1; if_pc = '0; ex_valid = 0; ex_is_jump = 0; ex_pc = '0;
    ex_taken = 0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
    model_clear();

    step(1, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    idle(32'h100);
    // Taken branch with a not-taken prediction, then its allocated entry predicts taken.
    step(0, 32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
    idle(32'h100);
    repeat (3) ex_step(32'h100, 0, 32'h100, 0, 32'h0);
    idle(32'h100);
    // JAL allocation, then an alias one table-stride away evicts it.
    ex_step(32'h200, 1, 32'h200, 1, 32'h400);
    idle(32'h200);
    ex_step(32'h200, 0, 32'h200 + 4 * ENTRIES, 1, 32'h600);
    idle(32'h200);
    idle(32'h200 + 4 * ENTRIES);
    // Same-index lookup and update in one cycle.
    ex_step(32'h300, 0, 32'h300, 1, 32'h340);
    idle(32'h300);
    idle(32'hFFFF_FFFC);
    ex_step(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0);
    // Drive the statistics into saturation.
    repeat ((1 << CNT_W) + 3) step(0, 32'h100, 1, 0, 32'h104, 1, 32'h900, 0, 32'h108);
    idle(32'h100);
    step(1, 32'h104, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    idle(32'h104);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0)
        epc = 32'hFFFF_FFF8 + 32'(4 * $urandom_range(0, 1));
      else
        epc = 32'h1000 + 32'(4 * $urandom_range(0, 3 * ENTRIES - 1));
      ipc = ($urandom_range(0, 1) == 1) ? epc : 32'h1000 + 32'(4 * $urandom_range(0, 3 * ENTRIES - 1));
      v   = ($urandom_range(0, 4) != 0);
      j   = ($urandom_range(0, 5) == 0);
      tk  = j ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFC;
      model_pred(epc, pt, pg);
      if ($urandom_range(0, 3) == 0) begin
        pt = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) pg = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(0, 99) == 0)
        step(1, ipc, 0, 0, epc, tk, tgt, pt, pg);
      else
        step(0, ipc, v, j, epc, tk, tgt, pt, pg);
    end
    idle(32'h1000);

    repeat (2) @(negedge clk);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
